fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch buffer between the program-counter/instruction-memory stage (upstream) and instruction decode (downstream).
- Captures {PC, instruction} pairs produced by fetch and presents them to decode in order.
- Back-pressures fetch: holdPC = ~in_ready.
- Discards all buffered instructions on a taken branch/jump flush from ID.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width; log2(DEPTH).
- CNT_W, 3, occupancy counter width; log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue can accept; fetch holds PC when low.
- out_valid  output  1  head entry valid for decode.
- out_pc  output  32  PC of head entry.
- out_pc4  output  32  out_pc + 4, used for branch/link computation.
- out_instr  output  32  instruction of head entry.
- out_ready  input  1  decode consumes head this cycle (low = hazard stall).
- flush  input  1  taken branch/jump; discard all contents.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, active-high): clk and Reset as already decided. Clears wr_ptr, rd_ptr and count to 0 immediately, independent of clk. Storage contents are not cleared.
  - Output values during and after reset: out_valid=0, out_pc=0, out_pc4=4, out_instr=0, in_ready=1, count=0.
  - Reset asserted mid-operation drops all entries; any push or pop in that cycle is lost.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Push (posedge): write {in_pc, in_instr} at wr_ptr; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop (posedge): rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry pushed at edge N appears on out_* immediately after edge N (1-cycle latency). There is no combinational bypass from in_* to out_*, even when the queue is empty.
- Show-ahead outputs (combinational from storage and pointers):
  - out_valid = (count != 0).
  - When out_valid=1: out_pc and out_instr = entry[rd_ptr].
  - When out_valid=0: out_pc=0, out_instr=32'h00000000 (NOP), out_pc4=4.
  - out_pc4 = out_pc + 4, 32-bit, wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- in_ready = (count != DEPTH); combinational from registered count only.
  - Full: in_ready=0 even if decode pops the same cycle. No simultaneous push and pop on full.
  - Empty: out_valid=0; out_ready is ignored, with no underflow.
- Flush (synchronous, posedge): wr_ptr <= 0, rd_ptr <= 0, count <= 0.
  - Overrides push and pop in the same cycle. The in_* word presented during flush is discarded, and fetch must re-present from the redirected PC.
  - Effect is visible the cycle after the edge: out_valid=0, in_ready=1.
- Flush and Reset together: Reset wins; same end state.
- Ordering: strict FIFO. Entries are never reordered or duplicated. out_* holds steady while out_ready=0.
- Internal state: wr_ptr, rd_ptr, count and storage only. No separate FSM. Full/empty derive from count, not from pointer comparison.

Test Plan:
- Reset, then 4 pushes with out_ready=0 (PC 0x0/0x4/0x8/0xC, instr 0x20080001..4) -> count=4, in_ready=0, out_pc=0x0, out_pc4=0x4, out_instr=0x20080001; a 5th push attempt is ignored, count stays 4.
- From full, out_ready=1 for 4 cycles, in_valid=0 -> out_pc sequence 0x0,0x4,0x8,0xC, then out_valid=0, out_instr=0, count=0; an extra cycle of out_ready=1 causes no underflow.
- Streaming with in_valid=1 and out_ready=1, PC 0x100 upward for 10 cycles -> count holds at 1 after the first push, each PC is emitted exactly once in order, and pointers wrap twice without loss.
- Queue at count=3 with in_valid=1, out_ready=1, flush=1 -> next cycle count=0, out_valid=0, in_ready=1; the PC presented during flush never appears on out_pc.
- Reset asserted between clock edges while count=2 -> out_valid=0, count=0 and in_ready=1 immediately, before the next posedge.
- Push PC 0xFFFFFFFC -> out_pc4=0x00000000.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead fetch-to-decode instruction queue with flush
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc4,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic             push, pop;

  // Full/empty come only from the registered count, never from pointer compare.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign out_pc4   = out_pc + 32'd4;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale words are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    checks++; if (out_pc4 !== 32'h4) begin errors++; $display("FAIL reset_out_pc4 got %h exp 4", out_pc4); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = 32'h2008_0001 + 32'(i);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL fill_out_pc got %h exp 0", out_pc); end
    checks++; if (out_pc4 !== 32'h4) begin errors++; $display("FAIL fill_out_pc4 got %h exp 4", out_pc4); end
    checks++; if (out_instr !== 32'h2008_0001) begin errors++; $display("FAIL fill_out_instr got %h exp 20080001", out_instr); end
    in_pc = 32'h10; in_instr = 32'h2008_0005;
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got %0d exp 4", count); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL overflow_out_pc got %h exp 0", out_pc); end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_pc !== 32'(4 * i) || out_instr !== 32'h2008_0001 + 32'(i)) begin
        errors++; $display("FAIL drain_head[%0d] got pc %h instr %h exp pc %h instr %h",
                           i, out_pc, out_instr, 32'(4 * i), 32'h2008_0001 + 32'(i));
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL drain_out_instr got %h exp 0", out_instr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
    step();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL underflow got count %0d valid %0b exp 0 0", count, out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL underflow_in_ready got %0b exp 1", in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i); in_instr = 32'hA000_0000 + 32'(i);
      step();
      checks++;
      if (count !== 3'd1 || out_pc !== 32'h100 + 32'(4 * i) || out_instr !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL stream[%0d] got count %0d pc %h instr %h exp 1 %h %h",
                           i, count, out_pc, out_instr, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_instr = 32'hB000_0000 + 32'(i);
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL preflush_count got %0d exp 3", count); end
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'hDEAD_BEEF; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b exp 1", in_ready); end
    step();
    checks++; if (out_pc !== 32'h0 || count !== 3'd0) begin
      errors++; $display("FAIL flush_discard got pc %h count %0d exp 0 0", out_pc, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i); in_instr = 32'hC000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL prereset_count got %0d exp 2", count); end
    #2 Reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %0b exp 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %0b exp 1", in_ready); end
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_pc4_wrap();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_instr = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out_pc got %h exp fffffffc", out_pc); end
    checks++; if (out_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_out_pc4 got %h exp 0", out_pc4); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc4 !== 32'h4) begin errors++; $display("FAIL empty_out_pc4 got %h exp 4", out_pc4); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_pc4_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
